// File: rtl/pma_tx_sched.sv
// pma_tx_sched: slot scheduler between the PCS and a PISO serialiser.
//
// Opens one slot every LENGTH clk cycles. In each slot it presents a single
// code-group on parallel_out: the PCS word if one is offered, or IDLE_WORD
// if none is. It drives the PISO load/shift controls and counts how many
// idle words it has inserted.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   enable       in   1 = transmit path running
//   tx_valid     in   PCS code-group valid
//   tx_data      in   PCS code-group [LENGTH]
//   tx_ready     out  slot open (combinational); transfer when valid & ready
//   parallel_out out  word presented to the PISO parallel input [LENGTH]
//   s_start      out  PISO shift enable
//   load         out  one-cycle pulse marking a new parallel_out word
//   bit_cnt      out  bit position within the current word [4]
//   idle_cnt     out  saturating count of inserted idle words [8]
module pma_tx_sched #(
    parameter int unsigned          LENGTH    = 10,
    parameter logic [LENGTH-1:0]    IDLE_WORD = 10'b0011111010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tx_valid,
    input  logic [LENGTH-1:0] tx_data,
    output logic              tx_ready,
    output logic [LENGTH-1:0] parallel_out,
    output logic              s_start,
    output logic              load,
    output logic [3:0]        bit_cnt,
    output logic [7:0]        idle_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StShift
    } state_e;

    localparam logic [3:0] LastBit = 4'(LENGTH - 1);

    state_e              state_q, state_d;
    logic [LENGTH-1:0]   parallel_out_q, parallel_out_d;
    logic                s_start_q, s_start_d;
    logic                load_q, load_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          idle_cnt_q, idle_cnt_d;
    logic                last_bit;

    assign last_bit = (bit_cnt_q == LastBit);

    // A slot opens right after START, or at the last bit of a word while the
    // path is still enabled, so back-to-back words are LENGTH cycles apart.
    assign tx_ready = (state_q == StStart) ||
                      ((state_q == StShift) && last_bit && enable);

    always_comb begin
        state_d        = state_q;
        parallel_out_d = parallel_out_q;
        s_start_d      = s_start_q;
        load_d         = 1'b0;
        bit_cnt_d      = bit_cnt_q;
        idle_cnt_d     = idle_cnt_q;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StShift;
            end
            StShift: begin
                if (last_bit) begin
                    // Only reached with enable low here; an enabled last bit
                    // is handled as an accept below.
                    if (!enable) begin
                        state_d   = StIdle;
                        s_start_d = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tx_ready) begin
            state_d   = StShift;
            load_d    = 1'b1;
            s_start_d = 1'b1;
            bit_cnt_d = 4'd0;
            if (tx_valid) begin
                parallel_out_d = tx_data;
            end else begin
                parallel_out_d = IDLE_WORD;
                if (idle_cnt_q != 8'hFF) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            parallel_out_q <= '0;
            s_start_q      <= 1'b0;
            load_q         <= 1'b0;
            bit_cnt_q      <= 4'd0;
            idle_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            parallel_out_q <= parallel_out_d;
            s_start_q      <= s_start_d;
            load_q         <= load_d;
            bit_cnt_q      <= bit_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
        end
    end

    assign parallel_out = parallel_out_q;
    assign s_start      = s_start_q;
    assign load         = load_q;
    assign bit_cnt      = bit_cnt_q;
    assign idle_cnt     = idle_cnt_q;

endmodule

// File: doc/pma_tx_sched.md
PMA_TX_SCHED -- requirements
Module: pma_tx_sched

Interface
REQ-001 The block SHALL have parameter LENGTH, default 10: code-group width in bits and word slot length in clk cycles.
REQ-002 The block SHALL have parameter IDLE_WORD, default 10'b0011111010: K28.5 RD- comma inserted when no PCS word is available.
REQ-003 The block SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1: 1 = transmit path running.
REQ-006 The block SHALL have port tx_valid, input, 1: PCS code-group valid.
REQ-007 The block SHALL have port tx_data, input, LENGTH: PCS code-group.
REQ-008 The block SHALL have port tx_ready, output, 1: slot open; transfer occurs when tx_valid and tx_ready are both 1 at a rising edge.
REQ-009 The block SHALL have port parallel_out, output, LENGTH: word presented to the PISO parallel_in.
REQ-010 The block SHALL have port s_start, output, 1: PISO shift enable.
REQ-011 The block SHALL have port load, output, 1: one-cycle pulse marking a new parallel_out word.
REQ-012 The block SHALL have port bit_cnt, output, 4: bit position within the current word, 0..LENGTH-1.
REQ-013 The block SHALL have port idle_cnt, output, 8: count of inserted idle words, saturating.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, START and SHIFT.
REQ-015 IDLE SHALL go to START on the next edge when enable=1; otherwise it stays in IDLE.
REQ-016 START SHALL last exactly one cycle and then go to SHIFT.
REQ-017 tx_ready SHALL be combinational and equal 1 only when (state=START) or (state=SHIFT and bit_cnt=LENGTH-1 and enable=1).
REQ-018 At each edge where tx_ready=1, parallel_out SHALL register tx_data if tx_valid=1, else IDLE_WORD.
REQ-019 At each edge where tx_ready=1, the registered outputs SHALL be set to load=1, s_start=1 and bit_cnt=0.
REQ-020 Latency: a word accepted at edge E SHALL appear on parallel_out, together with load=1, immediately after E; this is the same edge, with zero added cycles.
REQ-021 load SHALL return to 0 after one cycle.
REQ-022 In SHIFT, bit_cnt SHALL increment by 1 each cycle and SHALL NOT exceed LENGTH-1.
REQ-023 Consecutive load pulses SHALL be exactly LENGTH cycles apart while enable=1.
REQ-024 parallel_out SHALL hold stable between load pulses.
REQ-025 tx_data SHALL be sampled only at accepting edges; a tx_valid without tx_ready SHALL be ignored, and the source holds its data.
REQ-026 Each IDLE_WORD insertion SHALL increment idle_cnt by 1, saturating at 255 with no wrap.
REQ-027 If enable falls mid-word, the current word SHALL complete through bit_cnt=LENGTH-1 with tx_ready=0 at that slot.
REQ-028 On the edge that completes a disabled word, the block SHALL go to IDLE with s_start=0, bit_cnt=0 and parallel_out held.
REQ-029 If enable drops and then returns before the slot end, the word SHALL continue uninterrupted.
REQ-030 Returning to IDLE and then re-enabling SHALL pass through START again.
REQ-031 If tx_valid=1 during IDLE, no transfer SHALL occur.

Reset
REQ-032 When reset=0, the block SHALL immediately (asynchronously) set state=IDLE, parallel_out=0, s_start=0, load=0, bit_cnt=0 and idle_cnt=0, so that tx_ready=0.
REQ-033 Reset mid-word SHALL abort the word with no completion.
REQ-034 After reset rises, behaviour SHALL restart per REQ-015.

Verification
REQ-035 Reset test: stimulus is reset=0 asserted between edges during SHIFT with bit_cnt=5; all outputs SHALL be 0 before the next edge.
REQ-036 First-word test: stimulus is enable=1 at edge 0 with tx_valid=1 and tx_data=10'b1010101111; the response SHALL be START at edge 1, accept at edge 2, parallel_out=10'b1010101111 with load=1, and s_start=1 from edge 2.
REQ-037 Back-to-back test: stimulus is a stream 10'h155, 10'h2AA, 10'h3FF with tx_valid held; the response SHALL be three accepts spaced 10 cycles apart, idle_cnt=0, and bit_cnt cycling 0..9.
REQ-038 Idle-insertion test: stimulus is tx_valid=0 for 3 slots; the response SHALL be parallel_out=10'b0011111010 with idle_cnt=3.
REQ-039 Saturation test: stimulus is 300 idle slots; the response SHALL be idle_cnt=255.
REQ-040 Disable test: stimulus is enable=0 at bit_cnt=4; the response SHALL be bit_cnt continuing to 9, tx_ready=0 at the slot end, then state IDLE with s_start=0 and no further load.
